// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on a command, waits for the camera
// start-of-frame, then streams a header word plus one frame of pixels
// into the image FIFO. Never stalls the camera. Pixels that arrive while
// the FIFO is full are dropped and counted.
module frame_capture_ctrl #(
    parameter int unsigned PIX_PER_FRAME = 76800,
    parameter logic [7:0]  HDR_TAG       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [7:0]  cmd_frames,
    input  logic        cmd_abort,
    input  logic        img_sync,
    input  logic        img_valid,
    input  logic [31:0] img_data,
    output logic        img_ready,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_din,
    input  logic        fifo_full,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frames_done,
    output logic [7:0]  drop_count,
    output logic [7:0]  short_count
);

    localparam int unsigned PIX_W = $clog2(PIX_PER_FRAME + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_FRAME);

    typedef enum logic [1:0] {StIdle, StArm, StStream} state_t;

    state_t           state;
    logic [7:0]       frames_left;   // 0 means continuous capture
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] pix_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The camera is never back-pressured.
    assign img_ready = 1'b1;
    assign busy      = (state != StIdle);
    assign pix_next  = pix_cnt + PIX_W'(1);

    // Capture FSM with registered FIFO write port and status counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            frames_left <= 8'd0;
            pix_cnt     <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_din    <= 32'd0;
            done        <= 1'b0;
            frames_done <= 8'd0;
            drop_count  <= 8'd0;
            short_count <= 8'd0;
        end else begin
            fifo_wr_en <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_start && !cmd_abort) begin
                        frames_left <= cmd_frames;
                        frames_done <= 8'd0;
                        drop_count  <= 8'd0;
                        short_count <= 8'd0;
                        state       <= StArm;
                    end
                end
                StArm: begin
                    if (cmd_abort) begin
                        state <= StIdle;
                    end else if (img_sync) begin
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            fifo_din   <= {HDR_TAG, frames_done, 16'h0000};
                            pix_cnt    <= '0;
                            state      <= StStream;
                        end else begin
                            drop_count <= sat_inc(drop_count);
                        end
                    end
                end
                StStream: begin
                    if (cmd_abort) begin
                        state <= StIdle;
                    end else if (img_sync) begin
                        // Early sync: abandon the short frame and restart on this one.
                        short_count <= sat_inc(short_count);
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            fifo_din   <= {HDR_TAG, frames_done, 16'h0000};
                            pix_cnt    <= '0;
                        end else begin
                            drop_count <= sat_inc(drop_count);
                            state      <= StArm;
                        end
                    end else if (img_valid) begin
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            fifo_din   <= img_data;
                        end else begin
                            drop_count <= sat_inc(drop_count);
                        end
                        if (pix_next == PIX_LAST) begin
                            frames_done <= frames_done + 8'd1;
                            pix_cnt     <= '0;
                            if (frames_left == 8'd1) begin
                                done  <= 1'b1;
                                state <= StIdle;
                            end else begin
                                if (frames_left != 8'd0) begin
                                    frames_left <= frames_left - 8'd1;
                                end
                                state <= StArm;
                            end
                        end else begin
                            pix_cnt <= pix_next;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl with a 4-pixel frame.
module tb_frame_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start, cmd_abort, img_sync, img_valid, fifo_full;
    logic [7:0]  cmd_frames;
    logic [31:0] img_data;
    logic        img_ready, fifo_wr_en, busy, done;
    logic [31:0] fifo_din;
    logic [7:0]  frames_done, drop_count, short_count;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    frame_capture_ctrl #(
        .PIX_PER_FRAME(4),
        .HDR_TAG(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_start(cmd_start),
        .cmd_frames(cmd_frames),
        .cmd_abort(cmd_abort),
        .img_sync(img_sync),
        .img_valid(img_valid),
        .img_data(img_data),
        .img_ready(img_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din),
        .fifo_full(fifo_full),
        .busy(busy),
        .done(done),
        .frames_done(frames_done),
        .drop_count(drop_count),
        .short_count(short_count)
    );

    // Monitor: every FIFO write is matched against the expected-word queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_wr_en) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL fifo_write_unexpected got=%h required=none", fifo_din);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (fifo_din !== e) begin
                        failures++;
                        $display("FAIL fifo_din got=%h required=%h", fifo_din, e);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Each stimulus task starts on a negedge and returns on the next one.
    task automatic img(input logic s, input logic v, input logic [31:0] d, input logic f);
        img_sync = s; img_valid = v; img_data = d; fifo_full = f;
        @(negedge clk);
    endtask

    task automatic cmd(input logic st, input logic ab, input logic [7:0] n);
        cmd_start = st; cmd_abort = ab; cmd_frames = n;
        img_sync = 1'b0; img_valid = 1'b0; img_data = 32'd0; fifo_full = 1'b0;
        @(negedge clk);
        cmd_start = 1'b0; cmd_abort = 1'b0;
    endtask

    task automatic idle(input int n);
        img_sync = 1'b0; img_valid = 1'b0; img_data = 32'd0; fifo_full = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic new_test();
        idle(2);
        wr_cnt = 0;
        done_cnt = 0;
        exp_q.delete();
    endtask

    task automatic frame(input logic [31:0] hdr, input logic [31:0] base);
        exp_q.push_back(hdr);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(base + 32'(i));
            img(1'b0, 1'b1, base + 32'(i), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_start = 1'b0; cmd_abort = 1'b0; cmd_frames = 8'd0;
        img_sync = 1'b0; img_valid = 1'b0; img_data = 32'd0; fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_din", fifo_din, 32'd0);
        chk("rst_img_ready", 32'(img_ready), 32'd1);
        chk("rst_counters", {frames_done, drop_count, short_count, 7'd0, done}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Single frame.
        new_test();
        cmd(1'b1, 1'b0, 8'd1);
        chk("arm_busy", 32'(busy), 32'd1);
        frame(32'hA500_0000, 32'd0);
        idle(3);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_frames_done", 32'(frames_done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_q_empty", exp_q.size(), 0);

        // Two frames, second header carries frame index 1.
        new_test();
        cmd(1'b1, 1'b0, 8'd2);
        frame(32'hA500_0000, 32'd10);
        chk("t2_mid_done_cnt", done_cnt, 0);
        frame(32'hA501_0000, 32'd20);
        idle(3);
        chk("t2_wr_cnt", wr_cnt, 10);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_frames_done", 32'(frames_done), 32'd2);
        chk("t2_q_empty", exp_q.size(), 0);

        // FIFO full during pixels 2 and 3.
        new_test();
        cmd(1'b1, 1'b0, 8'd1);
        exp_q.push_back(32'hA500_0000);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        exp_q.push_back(32'd1);
        img(1'b0, 1'b1, 32'd1, 1'b0);
        img(1'b0, 1'b1, 32'd2, 1'b1);
        img(1'b0, 1'b1, 32'd3, 1'b1);
        exp_q.push_back(32'd4);
        img(1'b0, 1'b1, 32'd4, 1'b0);
        idle(3);
        chk("t3_drop", 32'(drop_count), 32'd2);
        chk("t3_frames_done", 32'(frames_done), 32'd1);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_q_empty", exp_q.size(), 0);

        // Short frame; sync collides with a valid pixel which is discarded.
        new_test();
        cmd(1'b1, 1'b0, 8'd1);
        exp_q.push_back(32'hA500_0000);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        exp_q.push_back(32'd1);
        img(1'b0, 1'b1, 32'd1, 1'b0);
        exp_q.push_back(32'd2);
        img(1'b0, 1'b1, 32'd2, 1'b0);
        exp_q.push_back(32'hA500_0000);
        img(1'b1, 1'b1, 32'd99, 1'b0);
        for (int i = 5; i <= 8; i++) begin
            exp_q.push_back(32'(i));
            img(1'b0, 1'b1, 32'(i), 1'b0);
        end
        idle(3);
        chk("t4_short", 32'(short_count), 32'd1);
        chk("t4_frames_done", 32'(frames_done), 32'd1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_wr_cnt", wr_cnt, 8);

        // Abort after two pixels; the abort-cycle pixel is not written.
        new_test();
        cmd(1'b1, 1'b0, 8'd1);
        exp_q.push_back(32'hA500_0000);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        exp_q.push_back(32'd1);
        img(1'b0, 1'b1, 32'd1, 1'b0);
        exp_q.push_back(32'd2);
        img(1'b0, 1'b1, 32'd2, 1'b0);
        img_valid = 1'b1; img_data = 32'd3; cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        img(1'b0, 1'b1, 32'd4, 1'b0);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        img(1'b0, 1'b1, 32'd5, 1'b0);
        idle(3);
        chk("t5_wr_cnt", wr_cnt, 3);
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_frames_done", 32'(frames_done), 32'd0);

        // Reset mid-stream, then pixels keep coming without a new start.
        new_test();
        cmd(1'b1, 1'b0, 8'd1);
        exp_q.push_back(32'hA500_0000);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        exp_q.push_back(32'd1);
        img(1'b0, 1'b1, 32'd1, 1'b0);
        img_data = 32'd2;
        #2 reset = 1'b1;
        #1;
        chk("t6_async_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_din", fifo_din, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wr_cnt = 0;
        img(1'b0, 1'b1, 32'd3, 1'b0);
        img(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 4; i <= 8; i++) img(1'b0, 1'b1, 32'(i), 1'b0);
        idle(2);
        chk("t6_wr_cnt", wr_cnt, 0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_counters", {frames_done, drop_count, short_count, 7'd0, done}, 32'd0);
        chk("t6_img_ready", 32'(img_ready), 32'd1);

        // Continuous run: drop_count saturates, start while busy is ignored.
        new_test();
        cmd(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 260; i++) img(1'b1, 1'b0, 32'd0, 1'b1);
        chk("t7_drop_sat", 32'(drop_count), 32'd255);
        cmd(1'b1, 1'b0, 8'd3);
        chk("t7_start_ignored", 32'(drop_count), 32'd255);
        frame(32'hA500_0000, 32'd40);
        frame(32'hA501_0000, 32'd50);
        idle(3);
        chk("t7_busy", 32'(busy), 32'd1);
        chk("t7_frames_done", 32'(frames_done), 32'd2);
        chk("t7_done_cnt", done_cnt, 0);
        cmd(1'b0, 1'b1, 8'd0);
        chk("t7_abort_busy", 32'(busy), 32'd0);
        chk("t7_q_empty", exp_q.size(), 0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter PIX_PER_FRAME, default 76800, meaning pixels per complete frame (320x240).
REQ-002 SHALL have parameter HDR_TAG, default 8'hA5, meaning the tag byte in each frame header word.
REQ-003 SHALL have port clk, in, 1, the single clock (bus_clk domain); all logic on its rising edge.
REQ-004 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have port cmd_start, in, 1, one-cycle pulse that starts a capture run.
REQ-006 SHALL have port cmd_frames, in, 8, frames to capture, sampled on cmd_start; 0 means continuous.
REQ-007 SHALL have port cmd_abort, in, 1, one-cycle pulse that stops any run.
REQ-008 SHALL have port img_sync, in, 1, start-of-frame pulse from camera; no pixel on that cycle.
REQ-009 SHALL have ports img_valid, in, 1 and img_data, in, 32: formatted pixel and its qualifier.
REQ-010 SHALL have port img_ready, out, 1, always 1 after reset; block never stalls the camera.
REQ-011 SHALL have ports fifo_wr_en, out, 1; fifo_din, out, 32; fifo_full, in, 1: image FIFO write side.
REQ-012 SHALL have status outputs busy (1), done (1, pulse), frames_done (8), drop_count (8), short_count (8).

Function
REQ-013 SHALL implement states IDLE, ARM, STREAM; busy=1 in ARM and STREAM.
REQ-014 IDLE: on cmd_start (no abort), latch cmd_frames to frames_left, clear frames_done/drop_count/short_count, go ARM next cycle.
REQ-015 cmd_start while busy SHALL be ignored; cmd_abort and cmd_start in the same cycle: abort wins.
REQ-016 ARM: pixels discarded; on img_sync with fifo_full=0, write header {HDR_TAG, frames_done, 16'h0000}, clear pix_cnt, go STREAM.
REQ-017 ARM: on img_sync with fifo_full=1, no write, drop_count+1, remain ARM.
REQ-018 STREAM: each img_valid cycle increments pix_cnt; fifo_wr_en=1 with fifo_din=img_data when fifo_full=0, else pixel dropped and drop_count+1.
REQ-019 STREAM: the cycle pix_cnt reaches PIX_PER_FRAME, frames_done+1 (wraps modulo 256); if frames_left==1, go IDLE and pulse done for one cycle; else decrement frames_left (unless continuous), go ARM.
REQ-020 STREAM: img_sync before pix_cnt reaches PIX_PER_FRAME: short_count+1, frame not counted, treated as a new frame start per REQ-016/017 in that same cycle.
REQ-021 img_valid and img_sync in the same cycle: img_sync wins, pixel discarded, not counted.
REQ-022 drop_count and short_count SHALL saturate at 255.
REQ-023 cmd_abort in ARM or STREAM: next state IDLE, no write that cycle, done not pulsed, counters held.
REQ-024 fifo_wr_en SHALL be combinational-free (registered), one cycle latency from img_valid/img_sync to write; fifo_wr_en never asserted while sampled fifo_full=1.
REQ-025 pix_cnt width SHALL be ceil(log2(PIX_PER_FRAME+1)) bits.

Reset
REQ-026 reset SHALL asynchronously force state IDLE, fifo_wr_en=0, fifo_din=0, done=0, busy=0, all counters and frames_left to 0; img_ready=1.
REQ-027 reset mid-frame SHALL discard the partial frame with no further FIFO writes; capture restarts only on a new cmd_start.

Verification (PIX_PER_FRAME=4)
REQ-028 cmd_start, cmd_frames=1; sync then 4 pixels 1..4 -> FIFO gets 32'hA5000000,1,2,3,4; done pulses once; frames_done=1; busy=0.
REQ-029 cmd_frames=2; two full frames -> headers A5000000 and A5010000, 10 words total, done after second frame.
REQ-030 fifo_full=1 during pixels 2-3 of one frame -> FIFO gets header,1,4; drop_count=2; frames_done=1.
REQ-031 sync after 2 pixels then full frame -> short_count=1, frames_done=1, second header A5000000.
REQ-032 cmd_abort during STREAM after 2 pixels -> IDLE next cycle, no more writes, no done, frames_done=0.
REQ-033 reset asserted mid-STREAM, released, pixels continue without cmd_start -> all outputs at reset values, zero FIFO writes.
